// File: rtl/imm_gen_stream.sv
// ---------------------------------------------------------------------------
// imm_gen_stream : RV32I/RV64I immediate decoder feeding a DEPTH-entry FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imm_gen_stream #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  localparam logic [2:0] FMT_I   = 3'd0;
  localparam logic [2:0] FMT_S   = 3'd1;
  localparam logic [2:0] FMT_B   = 3'd2;
  localparam logic [2:0] FMT_U   = 3'd3;
  localparam logic [2:0] FMT_J   = 3'd4;
  localparam logic [2:0] FMT_R   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [2:0]       fmt_mem_q [DEPTH];
  logic             ill_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic [63:0] dec_imm64;
  logic [2:0]  dec_fmt;
  logic        dec_ill;
  logic        push;
  logic        pop;

  // Immediates are built at 64 bits and truncated, so one decoder serves both XLENs.
  always_comb begin
    dec_imm64 = '0;
    dec_fmt   = FMT_ILL;
    dec_ill   = 1'b0;
    unique case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_fmt   = FMT_I;
        dec_imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt   = FMT_I;
          dec_imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm64 = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm64 = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm64 = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
      end
      7'b0110011: dec_fmt = FMT_R;
      7'b0111011: begin
        if (XLEN == 64) dec_fmt = FMT_R;
        else            dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_ready  = rst_n & (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    // Counting happens on accept, so it is independent of flush.
    if (push && dec_ill && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + CNT_W'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + OCC_W'(1);
      else if (!push && pop) count_d = count_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ill_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  // Payload storage needs no reset: entries are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      imm_mem_q[wr_ptr_q] <= dec_imm64[XLEN-1:0];
      fmt_mem_q[wr_ptr_q] <= dec_fmt;
      ill_mem_q[wr_ptr_q] <= dec_ill;
    end
  end

  assign out_imm     = out_valid ? imm_mem_q[rd_ptr_q] : '0;
  assign out_fmt     = out_valid ? fmt_mem_q[rd_ptr_q] : 3'd0;
  assign out_illegal = out_valid ? ill_mem_q[rd_ptr_q] : 1'b0;
  assign illegal_cnt = ill_cnt_q;

endmodule

`default_nettype wire
